pipe_stage_reg: RTL and testbench

Generic pipeline stage register that replaces the fixed, per-stage boundary registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a parametrised data payload and a control bundle across a stage boundary using a valid/ready handshake. It supports a synchronous flush that inserts bubbles, and an optional 2-entry skid buffer so that `in_ready` is registered. A saturating stall counter is provided for performance debug.

---
 rtl/pipe_stage_reg.sv | 148 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with flush-to-bubble, optional
// 2-entry skid buffer (registered in_ready) and a saturating stall counter.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state;
    state_t            stateNext;
    logic [DATA_W-1:0] mainData;
    logic [CTRL_W-1:0] mainCtrl;
    logic [DATA_W-1:0] skidData;
    logic [CTRL_W-1:0] skidCtrl;
    logic [CNT_W-1:0]  stallCnt;
    logic              outValid;
    logic              acc;
    logic              drn;
    logic              loadMainIn;
    logic              loadMainSkid;
    logic              loadSkid;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    assign outValid = (state != ST_EMPTY);
    assign acc      = in_valid & in_ready;
    assign drn      = outValid & out_ready;

    // in_ready: registered from the next state with a skid slot, otherwise a
    // plain combinational pass-through of downstream readiness.
    generate
        if (SKID != 0) begin : gSkid
            logic readyReg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) readyReg <= 1'b0;
                else     readyReg <= (stateNext != ST_SKID);
            end
            assign in_ready = readyReg & ~flush;
        end else begin : gNoSkid
            logic rstDone;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) rstDone <= 1'b0;
                else     rstDone <= 1'b1;
            end
            assign in_ready = rstDone & ~flush & (~outValid | out_ready);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_EMPTY;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext    = state;
        loadMainIn   = 1'b0;
        loadMainSkid = 1'b0;
        loadSkid     = 1'b0;
        if (flush) begin
            stateNext = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (acc) begin
                        stateNext  = ST_FULL;
                        loadMainIn = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (acc && drn) begin
                        loadMainIn = 1'b1;
                    end else if (acc) begin
                        stateNext = ST_SKID;
                        loadSkid  = 1'b1;
                    end else if (drn) begin
                        stateNext = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (drn) begin
                        stateNext    = ST_FULL;
                        loadMainSkid = 1'b1;
                    end
                end
                default: stateNext = ST_EMPTY;
            endcase
        end
    end

    // Main entry feeds the outputs; control is zeroed whenever it becomes a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mainData <= '0;
            mainCtrl <= '0;
            skidData <= '0;
            skidCtrl <= '0;
        end else begin
            if (loadMainIn) begin
                mainData <= in_data;
                mainCtrl <= in_ctrl;
            end else if (loadMainSkid) begin
                mainData <= skidData;
                mainCtrl <= skidCtrl;
            end else if (stateNext == ST_EMPTY) begin
                mainCtrl <= '0;
            end
            if (loadSkid) begin
                skidData <= in_data;
                skidCtrl <= in_ctrl;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       stallCnt <= '0;
        else if (outValid & ~out_ready) stallCnt <= satInc(stallCnt);
    end

    assign out_valid = outValid;
    assign out_data  = mainData;
    assign out_ctrl  = mainCtrl;
    assign stall_cnt = stallCnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: one skid instance (A) and one
// non-skid, 4-bit-counter instance (B), each with its own output monitor.
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstA, flushA, aInValid, aInReady, aOutValid, aOutReady;
    logic [31:0] aInData, aOutData;
    logic [7:0]  aInCtrl, aOutCtrl;
    logic [15:0] aStallCnt;

    logic        rstB, flushB, bInValid, bInReady, bOutValid, bOutReady;
    logic [31:0] bInData, bOutData;
    logic [7:0]  bInCtrl, bOutCtrl;
    logic [3:0]  bStallCnt;

    logic [39:0] qA[$];
    logic [39:0] qB[$];
    logic [39:0] expA, expB;
    int nChecks = 0;
    int nFails  = 0;

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(1), .CNT_W(16)) dutA (
        .clk(clk), .rst(rstA), .flush(flushA),
        .in_valid(aInValid), .in_ready(aInReady), .in_data(aInData), .in_ctrl(aInCtrl),
        .out_valid(aOutValid), .out_ready(aOutReady), .out_data(aOutData), .out_ctrl(aOutCtrl),
        .stall_cnt(aStallCnt)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(0), .CNT_W(4)) dutB (
        .clk(clk), .rst(rstB), .flush(flushB),
        .in_valid(bInValid), .in_ready(bInReady), .in_data(bInData), .in_ctrl(bInCtrl),
        .out_valid(bOutValid), .out_ready(bOutReady), .out_data(bOutData), .out_ctrl(bOutCtrl),
        .stall_cnt(bStallCnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic nextCyc();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rstA && aOutValid && aOutReady) begin
            if (qA.size() == 0) begin
                nChecks++;
                nFails++;
                $display("FAIL monA_unexpected: got data %0h, expected no output", aOutData);
            end else begin
                expA = qA.pop_front();
                chk("monA_data", 64'(aOutData), 64'(expA[39:8]));
                chk("monA_ctrl", 64'(aOutCtrl), 64'(expA[7:0]));
            end
        end
    end

    always @(negedge clk) begin
        if (!rstB && bOutValid && bOutReady) begin
            if (qB.size() == 0) begin
                nChecks++;
                nFails++;
                $display("FAIL monB_unexpected: got data %0h, expected no output", bOutData);
            end else begin
                expB = qB.pop_front();
                chk("monB_data", 64'(bOutData), 64'(expB[39:8]));
                chk("monB_ctrl", 64'(bOutCtrl), 64'(expB[7:0]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstA = 1'b1; flushA = 1'b0; aInValid = 1'b0; aInData = '0; aInCtrl = '0; aOutReady = 1'b0;
        rstB = 1'b1; flushB = 1'b0; bInValid = 1'b0; bInData = '0; bInCtrl = '0; bOutReady = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_a_in_ready",  64'(aInReady),  64'd0);
        chk("rst_a_out_valid", 64'(aOutValid), 64'd0);
        chk("rst_a_out_data",  64'(aOutData),  64'd0);
        chk("rst_a_out_ctrl",  64'(aOutCtrl),  64'd0);
        chk("rst_a_stall",     64'(aStallCnt), 64'd0);
        chk("rst_b_in_ready",  64'(bInReady),  64'd0);
        nextCyc();
        rstA = 1'b0; rstB = 1'b0;
        nextCyc();
        @(negedge clk);
        chk("post_rst_a_in_ready", 64'(aInReady), 64'd1);
        chk("post_rst_b_in_ready", 64'(bInReady), 64'd1);
        nextCyc();

        // test 1: streaming, latency 1
        aOutReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                aInValid = 1'b1;
                aInData  = 32'h10 + 32'(i);
                aInCtrl  = 8'h5A;
                qA.push_back({aInData, aInCtrl});
            end else begin
                aInValid = 1'b0;
            end
            @(negedge clk);
            chk("t1_in_ready", 64'(aInReady), 64'd1);
            if (i > 0) chk("t1_out_valid", 64'(aOutValid), 64'd1);
            nextCyc();
        end
        @(negedge clk);
        chk("t1_bubble_valid", 64'(aOutValid), 64'd0);
        chk("t1_bubble_ctrl",  64'(aOutCtrl),  64'd0);
        chk("t1_bubble_data",  64'(aOutData),  64'h13);
        chk("t1_stall",        64'(aStallCnt), 64'd0);
        nextCyc();

        // test 2: skid capture under 3-cycle stall
        aInValid = 1'b1; aInData = 32'hAA; aInCtrl = 8'hC1; aOutReady = 1'b1;
        qA.push_back({aInData, aInCtrl});
        @(negedge clk); nextCyc();
        aInData = 32'hBB; aInCtrl = 8'hC2; aOutReady = 1'b0;
        qA.push_back({aInData, aInCtrl});
        @(negedge clk); chk("t2_c1_in_ready", 64'(aInReady), 64'd1); nextCyc();
        aInData = 32'hCC; aInCtrl = 8'hC3;
        qA.push_back({aInData, aInCtrl});
        @(negedge clk); chk("t2_c2_in_ready", 64'(aInReady), 64'd0); nextCyc();
        @(negedge clk);
        chk("t2_c3_in_ready", 64'(aInReady), 64'd0);
        chk("t2_c3_hold_data", 64'(aOutData), 64'hAA);
        chk("t2_c3_hold_ctrl", 64'(aOutCtrl), 64'hC1);
        nextCyc();
        aOutReady = 1'b1;
        @(negedge clk);
        chk("t2_c4_in_ready", 64'(aInReady), 64'd0);
        chk("t2_c4_stall",    64'(aStallCnt), 64'd3);
        nextCyc();
        @(negedge clk);
        chk("t2_c5_in_ready", 64'(aInReady), 64'd1);
        chk("t2_c5_out_data", 64'(aOutData), 64'hBB);
        nextCyc();
        aInValid = 1'b0;
        @(negedge clk); chk("t2_c6_out_data", 64'(aOutData), 64'hCC); nextCyc();
        @(negedge clk); chk("t2_c7_out_valid", 64'(aOutValid), 64'd0); nextCyc();

        // test 3: flush with both entries full
        aInValid = 1'b1; aInData = 32'h01; aInCtrl = 8'h33; aOutReady = 1'b0;
        @(negedge clk); nextCyc();
        aInData = 32'h02;
        @(negedge clk); chk("t3_d1_in_ready", 64'(aInReady), 64'd1); nextCyc();
        aInValid = 1'b0; flushA = 1'b1;
        @(negedge clk);
        chk("t3_flush_in_ready", 64'(aInReady), 64'd0);
        chk("t3_flush_out_valid", 64'(aOutValid), 64'd1);
        nextCyc();
        flushA = 1'b0;
        @(negedge clk);
        chk("t3_post_out_valid", 64'(aOutValid), 64'd0);
        chk("t3_post_out_ctrl",  64'(aOutCtrl),  64'd0);
        chk("t3_post_stall",     64'(aStallCnt), 64'd5);
        chk("t3_post_in_ready",  64'(aInReady),  64'd1);
        nextCyc();

        // test 4: flush coincident with an offer
        flushA = 1'b1; aInValid = 1'b1; aInData = 32'h77; aInCtrl = 8'h44; aOutReady = 1'b1;
        @(negedge clk); chk("t4_flush_in_ready", 64'(aInReady), 64'd0); nextCyc();
        flushA = 1'b0;
        qA.push_back({aInData, aInCtrl});
        @(negedge clk);
        chk("t4_not_taken", 64'(aOutValid), 64'd0);
        chk("t4_in_ready",  64'(aInReady),  64'd1);
        nextCyc();
        aInValid = 1'b0;
        @(negedge clk);
        chk("t4_out_valid", 64'(aOutValid), 64'd1);
        chk("t4_out_ctrl",  64'(aOutCtrl),  64'h44);
        nextCyc();
        @(negedge clk); chk("t4_empty", 64'(aOutValid), 64'd0); nextCyc();

        // drain in a flush cycle is still a transfer
        aInValid = 1'b1; aInData = 32'h55; aInCtrl = 8'h66;
        qA.push_back({aInData, aInCtrl});
        @(negedge clk); nextCyc();
        aInValid = 1'b0; flushA = 1'b1;
        @(negedge clk); chk("tf_in_ready", 64'(aInReady), 64'd0); nextCyc();
        flushA = 1'b0;
        @(negedge clk);
        chk("tf_out_valid", 64'(aOutValid), 64'd0);
        chk("tf_out_ctrl",  64'(aOutCtrl),  64'd0);
        nextCyc();

        // test 5: no-skid combinational in_ready
        bInValid = 1'b1; bInData = 32'h21; bInCtrl = 8'h0F; bOutReady = 1'b0;
        qB.push_back({bInData, bInCtrl});
        @(negedge clk); chk("t5_g0_in_ready", 64'(bInReady), 64'd1); nextCyc();
        bInData = 32'h22; bInCtrl = 8'h1E;
        @(negedge clk); chk("t5_g1_in_ready", 64'(bInReady), 64'd0); nextCyc();
        bOutReady = 1'b1;
        qB.push_back({bInData, bInCtrl});
        @(negedge clk); chk("t5_g2_in_ready", 64'(bInReady), 64'd1); nextCyc();
        bInValid = 1'b0;
        @(negedge clk);
        chk("t5_g3_out_valid", 64'(bOutValid), 64'd1);
        chk("t5_g3_out_data",  64'(bOutData),  64'h22);
        nextCyc();
        @(negedge clk);
        chk("t5_g4_out_valid", 64'(bOutValid), 64'd0);
        chk("t5_g4_stall",     64'(bStallCnt), 64'd1);
        nextCyc();

        // test 6: saturation, then async reset mid-stall
        bInValid = 1'b1; bInData = 32'h66; bInCtrl = 8'h01; bOutReady = 1'b0;
        @(negedge clk); nextCyc();
        bInValid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); nextCyc();
        end
        @(negedge clk);
        chk("t6_stall_sat", 64'(bStallCnt), 64'd15);
        chk("t6_out_valid", 64'(bOutValid), 64'd1);
        #2;
        rstB = 1'b1;
        #1;
        chk("t6_rst_out_valid", 64'(bOutValid), 64'd0);
        chk("t6_rst_stall",     64'(bStallCnt), 64'd0);
        chk("t6_rst_in_ready",  64'(bInReady),  64'd0);
        chk("t6_rst_out_ctrl",  64'(bOutCtrl),  64'd0);
        nextCyc();
        rstB = 1'b0;
        nextCyc();
        @(negedge clk); chk("t6_resume_in_ready", 64'(bInReady), 64'd1); nextCyc();
        bInValid = 1'b1; bInData = 32'h99; bInCtrl = 8'h05; bOutReady = 1'b1;
        qB.push_back({bInData, bInCtrl});
        @(negedge clk); nextCyc();
        bInValid = 1'b0;
        @(negedge clk); chk("t6_after_valid", 64'(bOutValid), 64'd1); nextCyc();
        @(negedge clk); chk("t6_after_empty", 64'(bOutValid), 64'd0); nextCyc();

        chk("qA_drained", 64'(qA.size()), 64'd0);
        chk("qB_drained", 64'(qB.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
